// File: rtl/intc_pkg.sv
// Shared definitions for the parameterised interrupt controller: register map,
// handshake state encoding and address-decode helper.
package intc_pkg;

  localparam int IDX_W = 4;

  localparam logic [7:0] ISR_BASE    = 8'h00;
  localparam logic [7:0] ENABLE_OFS  = 8'h40;
  localparam logic [7:0] PENDING_OFS = 8'h44;
  localparam logic [7:0] STATUS_OFS  = 8'h48;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Word-aligned offset that falls inside the ISR table of num_ch entries.
  function automatic logic ofs_is_table(input logic [7:0] ofs, input int num_ch);
    logic [7:0] rel;
    rel = ofs - ISR_BASE;
    return (rel[1:0] == 2'b00) && (int'(rel[7:2]) < num_ch);
  endfunction

endpackage

// File: rtl/intc_arbiter.sv
// Rotating-start priority search: the first requester at or after ptr+1
// (mod NUM_CH) wins. A pointer of NUM_CH-1 yields plain lowest-index priority.
module intc_arbiter
  import intc_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic              valid,
  output logic [IDX_W-1:0]  idx
);

  logic hit_s;

  // Scan candidates in search order; only the first hit updates idx.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    hit_s = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      for (int j = 0; j < NUM_CH; j++) begin
        hit_s = req[j] && (j == ((int'(ptr) + 1 + k) % NUM_CH)) && !valid;
        idx   = hit_s ? IDX_W'(j) : idx;
        valid = valid | hit_s;
      end
    end
  end

endmodule

// File: rtl/intc_param_ctrl.sv
// Parameterised interrupt controller: ISR table, enable/pending registers and
// an IRQ/IACK handshake. Define INTC_ROUND_ROBIN_EN for round-robin arbitration.
module intc_param_ctrl
  import intc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] done,
  input  logic              IACK,
  input  logic [ADDR_W-1:0] input_addr,
  input  logic              write_enable,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              IRQ,
  output logic [DATA_W-1:0] isr_addr,
  output logic              error
);

  logic [DATA_W-1:0] table_r [NUM_CH];
  logic [NUM_CH-1:0] enable_r;
  logic [NUM_CH-1:0] pending_r;
  logic [NUM_CH-1:0] done_hist_r;
  logic              iack_hist_r;
  state_t            state_r;
  logic [IDX_W-1:0]  grant_r;
  logic [DATA_W-1:0] isr_addr_r;
  logic              irq_r;
  logic              error_r;

  logic [7:0]        ofs_s;
  logic              is_tab_s;
  logic [IDX_W-1:0]  tab_idx_s;
  logic              mapped_s;
  logic [NUM_CH-1:0] rise_s;
  logic [NUM_CH-1:0] w1c_s;
  logic [NUM_CH-1:0] ack_clr_s;
  logic              ack_s;
  logic [NUM_CH-1:0] req_s;
  logic              arb_valid_s;
  logic [IDX_W-1:0]  arb_idx_s;
  logic [IDX_W-1:0]  ptr_s;
  logic [DATA_W-1:0] tab_rd_s;
  logic [DATA_W-1:0] arb_vec_s;
  logic              unused_addr_s;

  assign ofs_s         = input_addr[7:0];
  assign unused_addr_s = ^input_addr[ADDR_W-1:8];
  assign is_tab_s      = ofs_is_table(ofs_s, NUM_CH);
  assign tab_idx_s     = IDX_W'(ofs_s[7:2]);
  assign mapped_s      = is_tab_s || (ofs_s == ENABLE_OFS) ||
                         (ofs_s == PENDING_OFS) || (ofs_s == STATUS_OFS);
  assign rise_s        = done & ~done_hist_r;
  assign w1c_s         = (write_enable && (ofs_s == PENDING_OFS)) ? write_data[NUM_CH-1:0] : '0;
  assign ack_s         = (state_r == REQ) && IACK;
  assign ack_clr_s     = ack_s ? (NUM_CH'(1) << grant_r) : '0;
  assign req_s         = pending_r & enable_r;

  intc_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req   (req_s),
    .ptr   (ptr_s),
    .valid (arb_valid_s),
    .idx   (arb_idx_s)
  );

`ifdef INTC_ROUND_ROBIN_EN
  logic [IDX_W-1:0] last_r;

  // Remember the most recently acknowledged channel to rotate the search.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_r <= IDX_W'(NUM_CH - 1);
    end else if (ack_s) begin
      last_r <= grant_r;
    end
  end

  assign ptr_s = last_r;
`else
  assign ptr_s = IDX_W'(NUM_CH - 1);
`endif

  // Table lookups for the register read path and the arbiter winner.
  always_comb begin
    tab_rd_s  = '0;
    arb_vec_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      tab_rd_s  = tab_rd_s  | ((is_tab_s && (tab_idx_s == IDX_W'(i))) ? table_r[i] : '0);
      arb_vec_s = arb_vec_s | ((arb_idx_s == IDX_W'(i)) ? table_r[i] : '0);
    end
  end

  // Combinational register read.
  always_comb begin
    read_data = '0;
    case (ofs_s)
      ENABLE_OFS:  read_data = DATA_W'(enable_r);
      PENDING_OFS: read_data = DATA_W'(pending_r);
      STATUS_OFS:  read_data = DATA_W'({grant_r, 3'b000, irq_r});
      default:     read_data = tab_rd_s;
    endcase
  end

  // Software-writable configuration: ISR table and enable mask.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        table_r[i] <= '0;
      end
      enable_r <= '0;
    end else if (write_enable) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (is_tab_s && (tab_idx_s == IDX_W'(i))) begin
          table_r[i] <= write_data;
        end
      end
      if (ofs_s == ENABLE_OFS) begin
        enable_r <= write_data[NUM_CH-1:0];
      end
    end
  end

  // Pending capture; a fresh edge overrides both W1C and acknowledge clears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_r   <= '0;
      done_hist_r <= '0;
      iack_hist_r <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      pending_r   <= (pending_r & ~w1c_s & ~ack_clr_s) | rise_s;
      done_hist_r <= done;
      iack_hist_r <= IACK;
      error_r     <= (write_enable && !mapped_s) ||
                     (IACK && !iack_hist_r && (state_r == IDLE));
    end
  end

  // Handshake FSM; grant and vector stay frozen from REQ entry until IACK.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      grant_r    <= '0;
      isr_addr_r <= '0;
      irq_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (arb_valid_s) begin
            state_r    <= REQ;
            grant_r    <= arb_idx_s;
            isr_addr_r <= arb_vec_s;
            irq_r      <= 1'b1;
          end
        end
        REQ: begin
          if (IACK) begin
            state_r <= WAIT;
            irq_r   <= 1'b0;
          end
        end
        WAIT: begin
          if (!IACK) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          irq_r   <= 1'b0;
        end
      endcase
    end
  end

  assign IRQ      = irq_r;
  assign isr_addr = isr_addr_r;
  assign error    = error_r;

endmodule

// File: tb/tb_intc_param_ctrl.sv
// Self-checking bench for intc_param_ctrl: directed scenarios then random
// traffic, all compared cycle by cycle against a behavioural model.
module tb_intc_param_ctrl;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [15:0] MASK = 16'((1 << NUM_CH) - 1);
  localparam int PH_IDLE = 0, PH_ASSERTED = 1, PH_ACKED = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] done;
  logic              IACK;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] read_data;
  logic              IRQ;
  logic [DATA_W-1:0] isr_addr;
  logic              error;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_table [NUM_CH];
  logic [15:0] m_en, m_pend, m_hist;
  logic        m_iack_prev, m_irq, m_err;
  logic [31:0] m_vec;
  int          m_grant, m_last, m_phase;

  intc_param_ctrl #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .done         (done),
    .IACK         (IACK),
    .input_addr   (addr),
    .write_enable (we),
    .write_data   (wdata),
    .read_data    (read_data),
    .IRQ          (IRQ),
    .isr_addr     (isr_addr),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_table(input logic [7:0] a);
    return (a % 4 == 0) && (int'(a) < 4 * NUM_CH);
  endfunction

  function automatic bit mapped(input logic [7:0] a);
    return is_table(a) || a == 8'h40 || a == 8'h44 || a == 8'h48;
  endfunction

  function automatic logic [31:0] exp_read(input logic [7:0] a);
    if (is_table(a)) return m_table[a / 4];
    if (a == 8'h40) return 32'(m_en);
    if (a == 8'h44) return 32'(m_pend);
    if (a == 8'h48) return 32'(m_grant * 16 + int'(m_irq));
    return 32'h0;
  endfunction

  function automatic int pick(input logic [15:0] req);
`ifdef INTC_ROUND_ROBIN_EN
    for (int k = 1; k <= NUM_CH; k++) if (req[(m_last + k) % NUM_CH]) return (m_last + k) % NUM_CH;
`else
    for (int i = 0; i < NUM_CH; i++) if (req[i]) return i;
`endif
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) m_table[i] = 32'h0;
    m_en = 16'h0; m_pend = 16'h0; m_hist = 16'h0;
    m_iack_prev = 1'b0; m_irq = 1'b0; m_err = 1'b0; m_vec = 32'h0;
    m_grant = 0; m_last = NUM_CH - 1; m_phase = PH_IDLE;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_next();
    logic [15:0] rise, np, req;
    logic [7:0]  a;
    logic        nerr;
    int          g;
    a    = addr[7:0];
    rise = 16'(done) & ~m_hist;
    np   = m_pend;
    if (we && a == 8'h44) np = np & ~(wdata[15:0] & MASK);
    if (m_phase == PH_ASSERTED && IACK) np[m_grant] = 1'b0;
    np   = (np | rise) & MASK;
    nerr = (we && !mapped(a)) || (IACK && !m_iack_prev && m_phase == PH_IDLE);
    req  = m_pend & m_en;
    if (m_phase == PH_IDLE && req != 16'h0) begin
      g = pick(req);
      m_grant = g; m_vec = m_table[g]; m_irq = 1'b1; m_phase = PH_ASSERTED;
    end else if (m_phase == PH_ASSERTED && IACK) begin
      m_irq = 1'b0; m_last = m_grant; m_phase = PH_ACKED;
    end else if (m_phase == PH_ACKED && !IACK) begin
      m_phase = PH_IDLE;
    end
    if (we && is_table(a)) m_table[a / 4] = wdata;
    if (we && a == 8'h40) m_en = wdata[15:0] & MASK;
    m_pend = np; m_err = nerr; m_hist = 16'(done); m_iack_prev = IACK;
  endtask

  task automatic tick();
    #1;
    check("read_data", read_data, exp_read(addr[7:0]));
    model_next();
    @(posedge clk);
    #1;
    check("irq", 32'(IRQ), 32'(m_irq));
    check("isr_addr", isr_addr, m_vec);
    check("error", 32'(error), 32'(m_err));
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    addr = {24'h0, a}; we = 1'b1; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic wait_irq(input string tag);
    int n;
    n = 0;
    while (!m_irq && n < 8) begin tick(); n++; end
    check(tag, 32'(IRQ), 32'd1);
  endtask

  task automatic handshake();
    IACK = 1'b1; tick();
    IACK = 1'b0; tick();
  endtask

  initial begin
    int first, second;
    logic [31:0] r;
    logic [7:0]  a;
    rst = 1'b0; done = '0; IACK = 1'b0; addr = '0; we = 1'b0; wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_irq", 32'(IRQ), 32'd0);
    check("rst_isr", isr_addr, 32'd0);
    check("rst_err", 32'(error), 32'd0);
    addr = 32'h40; #1;
    check("rst_enable", read_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Basic delivery with two-cycle latency
    wr(8'h08, 32'h0000_1200);
    wr(8'h40, 32'h4);
    done = 4'b0100; tick();
    check("lat_cycle1", 32'(IRQ), 32'd0);
    done = 4'b0000; tick();
    check("lat_cycle2", 32'(IRQ), 32'd1);
    check("vec_ch2", isr_addr, 32'h0000_1200);
    addr = 32'h44;
    IACK = 1'b1; tick();
    check("ack_irq", 32'(IRQ), 32'd0);
    check("ack_pend", read_data, 32'd0);
    IACK = 1'b0; tick();

    // Simultaneous requests on channels 1 and 3
    for (int i = 0; i < NUM_CH; i++) wr(8'(4 * i), 32'h100 * 32'(i + 1));
    wr(8'h40, 32'h2);
    done = 4'b0010; tick(); done = 4'b0000;
    wait_irq("irq_ch1");
    handshake();
    wr(8'h40, 32'hF);
`ifdef INTC_ROUND_ROBIN_EN
    first = 3; second = 1;
`else
    first = 1; second = 3;
`endif
    done = 4'b1010; tick(); done = 4'b0000;
    wait_irq("irq_first");
    addr = 32'h48; #1;
    check("grant_first", 32'(read_data[7:4]), 32'(first));
    check("vec_first", isr_addr, 32'h100 * 32'(first + 1));
    handshake();
    wait_irq("irq_second");
    addr = 32'h48; #1;
    check("grant_second", 32'(read_data[7:4]), 32'(second));
    check("vec_second", isr_addr, 32'h100 * 32'(second + 1));
    handshake();

    // Set beats W1C on the same bit
    wr(8'h40, 32'h0);
    done = 4'b0001; tick();
    done = 4'b0000; tick();
    done = 4'b0001; wr(8'h44, 32'h1);
    check("set_wins", 32'(read_data[0]), 32'd1);
    wr(8'h44, 32'h1);
    check("w1c_clears", 32'(read_data[0]), 32'd0);
    done = 4'b0000; tick();

    // Error pulses
    wr(8'h50, 32'hFFFF_FFFF);
    check("err_unmapped", 32'(error), 32'd1);
    tick();
    check("err_one_cycle", 32'(error), 32'd0);
    IACK = 1'b1; tick();
    check("err_iack_idle", 32'(error), 32'd1);
    IACK = 1'b0; tick();

    // Reset in the middle of a handshake
    wr(8'h40, 32'h1);
    done = 4'b0001; tick(); done = 4'b0000;
    wait_irq("irq_before_rst");
    #2 rst = 1'b0;
    #1 check("rst_async_irq", 32'(IRQ), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    addr = 32'h44; #1 check("rst_pend", read_data, 32'd0);
    addr = 32'h48; #1 check("rst_status", read_data, 32'd0);
    for (int i = 0; i < NUM_CH; i++) begin
      addr = 32'(4 * i); #1 check("rst_table", read_data, 32'd0);
    end

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      case ($urandom_range(0, 5))
        0: a = 8'(4 * $urandom_range(0, NUM_CH - 1));
        1: a = 8'h40;
        2: a = 8'h44;
        3: a = 8'h48;
        4: a = 8'h50;
        default: a = r[7:0];
      endcase
      addr  = {r[31:8], a};
      we    = ($urandom_range(0, 3) == 0);
      wdata = $urandom();
      if ($urandom_range(0, 1) == 0) done = done ^ NUM_CH'($urandom());
      if ($urandom_range(0, 2) == 0) IACK = ~IACK;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
